// File: rtl/bitslam_reg_writer.sv
// Register-write bus driver for the bitslam sound chip: queues commands in a FIFO and
// serialises each into an address phase and a data phase. Define BITSLAM_ADDR_ELIDE_EN to skip repeated address phases.
module bitslam_reg_writer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_addr,
    input  logic [5:0] cmd_data,
    input  logic [7:0] cmd_wait,
    output logic       bus_sel,
    output logic [5:0] bus_payload,
    output logic       busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, WAIT} state_t;

    typedef struct packed {
        logic [2:0] addr;
        logic [5:0] data;
        logic [7:0] hold;
    } cmd_t;

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_d;
    cmd_t          head;
    logic          push, pop;

    state_t        state, state_d;
    cmd_t          cur, cur_d;
    logic [2:0]    last_addr, last_addr_d;
    logic [7:0]    wait_cnt, wait_cnt_d;
    logic          do_exit;
`ifdef BITSLAM_ADDR_ELIDE_EN
    logic          addr_known, addr_known_d;
`endif

    logic          sel_d, busy_d, ready_d;
    logic [5:0]    payload_d;

    assign push = cmd_valid && cmd_ready;
    assign head = mem[rd_ptr];

    // NOTE: storage array has no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cmd_t'{addr: cmd_addr, data: cmd_data, hold: cmd_wait};
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d      = state;
        cur_d        = cur;
        last_addr_d  = last_addr;
        wait_cnt_d   = wait_cnt;
        do_exit      = 1'b0;
        pop          = 1'b0;
`ifdef BITSLAM_ADDR_ELIDE_EN
        addr_known_d = addr_known;
`endif

        unique case (state)
            IDLE: do_exit = 1'b1;
            ADDR: state_d = DATA;
            DATA: begin
                if (cur.hold != 8'd0) begin
                    wait_cnt_d = cur.hold;
                    state_d    = WAIT;
                end else begin
                    do_exit = 1'b1;
                end
            end
            WAIT: begin
                if (wait_cnt <= 8'd1) begin
                    wait_cnt_d = 8'd0;
                    do_exit    = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Shared exit rule: take the next queued command, or fall back to IDLE.
        if (do_exit) begin
            if (count != '0) begin
                pop   = 1'b1;
                cur_d = head;
`ifdef BITSLAM_ADDR_ELIDE_EN
                if (addr_known && head.addr == last_addr) begin
                    state_d = DATA;
                end else begin
                    state_d      = ADDR;
                    last_addr_d  = head.addr;
                    addr_known_d = 1'b1;
                end
`else
                state_d     = ADDR;
                last_addr_d = head.addr;
`endif
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        count_d   = count + (AW+1)'(push) - (AW+1)'(pop);
        sel_d     = (state_d == DATA);
        payload_d = sel_d ? cur_d.data : {3'b000, last_addr_d};
        busy_d    = (count_d != '0) || (state_d != IDLE);
        ready_d   = (count_d != FULL_COUNT);
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state       <= IDLE;
            cur         <= '0;
            last_addr   <= '0;
            wait_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            bus_sel     <= 1'b0;
            bus_payload <= '0;
            busy        <= 1'b0;
            cmd_ready   <= 1'b1;
`ifdef BITSLAM_ADDR_ELIDE_EN
            addr_known  <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            cur         <= cur_d;
            last_addr   <= last_addr_d;
            wait_cnt    <= wait_cnt_d;
            count       <= count_d;
            bus_sel     <= sel_d;
            bus_payload <= payload_d;
            busy        <= busy_d;
            cmd_ready   <= ready_d;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
`ifdef BITSLAM_ADDR_ELIDE_EN
            addr_known  <= addr_known_d;
`endif
        end
    end

endmodule

// File: tb/tb_bitslam_reg_writer.sv
// Directed bench for bitslam_reg_writer: per-cycle vector tables plus reset and wrap-around sequences.
module tb_bitslam_reg_writer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_addr;
    logic [5:0] cmd_data;
    logic [7:0] cmd_wait;
    logic       bus_sel;
    logic [5:0] bus_payload;
    logic       busy;

    bitslam_reg_writer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_wait    (cmd_wait),
        .bus_sel     (bus_sel),
        .bus_payload (bus_payload),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [2:0] addr;
        logic [5:0] data;
        logic [7:0] hold;
        logic       exp_sel;
        logic [5:0] exp_pay;
        logic       exp_busy;
        logic       exp_ready;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Packs sel/payload/busy/ready as {sel, payload[5:0], busy, ready}.
    function automatic logic [31:0] pack(logic s, logic [5:0] p, logic b, logic r);
        return {23'd0, s, p, b, r};
    endfunction

    function automatic void add(logic v, logic [2:0] a, logic [5:0] d, logic [7:0] h,
                                logic s, logic [5:0] p, logic b, logic r);
        vecs.push_back('{v, a, d, h, s, p, b, r});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            cmd_valid = vecs[i].valid;
            cmd_addr  = vecs[i].addr;
            cmd_data  = vecs[i].data;
            cmd_wait  = vecs[i].hold;
            step();
            check($sformatf("%s[%0d] {sel,pay,busy,rdy}", tag, i),
                  pack(bus_sel, bus_payload, busy, cmd_ready),
                  pack(vecs[i].exp_sel, vecs[i].exp_pay, vecs[i].exp_busy, vecs[i].exp_ready));
        end
        cmd_valid = 1'b0;
        vecs.delete();
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
        cmd_wait  = '0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset {sel,pay,busy,rdy}", pack(bus_sel, bus_payload, busy, cmd_ready),
              pack(1'b0, 6'h00, 1'b0, 1'b1));
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [5:0] exp_q[$];
        int         pushed, seen, cycles;
        bit         saw_full;

        do_reset();

        // Single write, then four back-to-back, then a write with a post-wait.
        add(1, 3'd4, 6'h2A, 8'd0, 0, 6'h00, 1, 1);
        add(0, 3'd0, 6'h00, 8'd0, 0, 6'h04, 1, 1);
        add(0, 3'd0, 6'h00, 8'd0, 1, 6'h2A, 1, 1);
        add(0, 3'd0, 6'h00, 8'd0, 0, 6'h04, 0, 1);
        add(0, 3'd0, 6'h00, 8'd0, 0, 6'h04, 0, 1);
        add(1, 3'd0, 6'h05, 8'd0, 0, 6'h04, 1, 1);
        add(1, 3'd1, 6'h0F, 8'd0, 0, 6'h00, 1, 1);
        add(1, 3'd2, 6'h11, 8'd0, 1, 6'h05, 1, 1);
        add(1, 3'd3, 6'h03, 8'd0, 0, 6'h01, 1, 1);
        add(0, 3'd0, 6'h00, 8'd0, 1, 6'h0F, 1, 1);
        add(0, 3'd0, 6'h00, 8'd0, 0, 6'h02, 1, 1);
        add(0, 3'd0, 6'h00, 8'd0, 1, 6'h11, 1, 1);
        add(0, 3'd0, 6'h00, 8'd0, 0, 6'h03, 1, 1);
        add(0, 3'd0, 6'h00, 8'd0, 1, 6'h03, 1, 1);
        add(0, 3'd0, 6'h00, 8'd0, 0, 6'h03, 0, 1);
        add(1, 3'd1, 6'h09, 8'd3, 0, 6'h03, 1, 1);
        add(1, 3'd5, 6'h3F, 8'd0, 0, 6'h01, 1, 1);
        add(0, 3'd0, 6'h00, 8'd0, 1, 6'h09, 1, 1);
        add(0, 3'd0, 6'h00, 8'd0, 0, 6'h01, 1, 1);
        add(0, 3'd0, 6'h00, 8'd0, 0, 6'h01, 1, 1);
        add(0, 3'd0, 6'h00, 8'd0, 0, 6'h01, 1, 1);
        add(0, 3'd0, 6'h00, 8'd0, 0, 6'h05, 1, 1);
        add(0, 3'd0, 6'h00, 8'd0, 1, 6'h3F, 1, 1);
        add(0, 3'd0, 6'h00, 8'd0, 0, 6'h05, 0, 1);
        run_vecs("basic");

        // Three writes to one register right after reset.
        do_reset();
`ifdef BITSLAM_ADDR_ELIDE_EN
        add(1, 3'd2, 6'h01, 8'd0, 0, 6'h00, 1, 1);
        add(1, 3'd2, 6'h02, 8'd0, 0, 6'h02, 1, 1);
        add(1, 3'd2, 6'h03, 8'd0, 1, 6'h01, 1, 1);
        add(0, 3'd0, 6'h00, 8'd0, 1, 6'h02, 1, 1);
        add(0, 3'd0, 6'h00, 8'd0, 1, 6'h03, 1, 1);
        add(0, 3'd0, 6'h00, 8'd0, 0, 6'h02, 0, 1);
`else
        add(1, 3'd2, 6'h01, 8'd0, 0, 6'h00, 1, 1);
        add(1, 3'd2, 6'h02, 8'd0, 0, 6'h02, 1, 1);
        add(1, 3'd2, 6'h03, 8'd0, 1, 6'h01, 1, 1);
        add(0, 3'd0, 6'h00, 8'd0, 0, 6'h02, 1, 1);
        add(0, 3'd0, 6'h00, 8'd0, 1, 6'h02, 1, 1);
        add(0, 3'd0, 6'h00, 8'd0, 0, 6'h02, 1, 1);
        add(0, 3'd0, 6'h00, 8'd0, 1, 6'h03, 1, 1);
        add(0, 3'd0, 6'h00, 8'd0, 0, 6'h02, 0, 1);
`endif
        run_vecs("same_reg");

        // Reset during a data phase with two commands still queued.
        do_reset();
        add(1, 3'd6, 6'h15, 8'd0, 0, 6'h00, 1, 1);
        add(1, 3'd7, 6'h16, 8'd0, 0, 6'h06, 1, 1);
        add(1, 3'd3, 6'h17, 8'd0, 1, 6'h15, 1, 1);
        run_vecs("pre_rst");
        rst = 1'b1;
        #1;
        check("mid-data reset {sel,pay,busy,rdy}", pack(bus_sel, bus_payload, busy, cmd_ready),
              pack(1'b0, 6'h00, 1'b0, 1'b1));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("post-reset quiet[%0d]", i), pack(bus_sel, bus_payload, busy, cmd_ready),
                  pack(1'b0, 6'h00, 1'b0, 1'b1));
        end
        add(1, 3'd5, 6'h2B, 8'd0, 0, 6'h00, 1, 1);
        add(0, 3'd0, 6'h00, 8'd0, 0, 6'h05, 1, 1);
        add(0, 3'd0, 6'h00, 8'd0, 1, 6'h2B, 1, 1);
        add(0, 3'd0, 6'h00, 8'd0, 0, 6'h05, 0, 1);
        run_vecs("after_rst");

        // Stream 3*DEPTH commands with cmd_valid held high; the FIFO fills and pointers wrap.
        do_reset();
        pushed   = 0;
        seen     = 0;
        cycles   = 0;
        saw_full = 1'b0;
        while ((pushed < 3*DEPTH || seen < 3*DEPTH) && cycles < 300) begin
            cmd_valid = (pushed < 3*DEPTH);
            cmd_addr  = 3'(pushed % 8);
            cmd_data  = 6'((pushed * 7 + 3) % 64);
            cmd_wait  = 8'd0;
            if (!cmd_ready) saw_full = 1'b1;
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back(cmd_data);
                pushed++;
            end
            step();
            cycles++;
            if (bus_sel) begin
                if (exp_q.size() == 0) begin
                    check("stream extra data phase", {26'd0, bus_payload}, 32'hFFFF_FFFF);
                end else begin
                    check($sformatf("stream data[%0d]", seen), {26'd0, bus_payload},
                          {26'd0, exp_q.pop_front()});
                end
                seen++;
            end
        end
        cmd_valid = 1'b0;
        check("stream data phases seen", seen, 3*DEPTH);
        check("stream fifo reached full", {31'd0, saw_full}, 32'd1);
        repeat (3) step();
        check("stream drained {sel,busy,rdy}", {29'd0, bus_sel, busy, cmd_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
